alu_md: RTL and testbench
=========================

# alu_md

Parametrised-width execute-stage ALU for the MIPS datapath. It keeps the single-cycle combinational ALU path and its 6-bit function encoding. It adds a sequential multiply/divide unit with HI/LO registers, driven by a start/busy/done handshake. It sits in EX, beside the forwarding muxes. The hazard unit stalls on `md_busy`.

## Interface
Parameters:
- `W`, 32: datapath width; power of two, 8..64.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  W  operand A; for shifts, `a[log2(W)-1:0]` is the shift amount.
- `b`  in  W  operand B.
- `fun`  in  6  ALU function code.
- `sign`  in  1  signed mode for overflow and compares.
- `z`  out  W  combinational ALU result.
- `ovf`  out  1  combinational signed overflow of add/sub.
- `md_start`  in  1  request a mult/div/move operation.
- `md_op`  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `md_sign`  in  1  signed mult/div.
- `md_busy`  out  1  unit occupied.
- `md_done`  out  1  one-cycle pulse; `hi`/`lo` have just been updated by MULT/DIV.
- `hi`  out  W  HI register.
- `lo`  out  W  LO register.

## Operation
Combinational path (`fun[5:4]` selects the group):
- 00 arithmetic: `fun[0]`=0 gives a+b; `fun[0]`=1 gives a−b.
  - Result is modulo 2^W.
  - `ovf`=1 only when `sign`=1 and signed overflow occurs.
  - `ovf`=0 in every other group.
- 01 logic, by `fun[3:0]`:
  - 1000 AND; 1110 OR; 0110 XOR; 0001 NOR; 1010 pass A.
  - Other codes give 0.
- 10 shift of B by amount from A, by `fun[1:0]`:
  - 00 SLL; 01 SRL; 11 SRA.
  - 10 gives 0.
- 11 compare:
  - Result is `{W-1 zeros, flag}`.
  - The flag comes from a−b' (b' = b, except b' = 0 when `fun[5:3]`=111).
  - Flag by `fun[3:1]`: 001 EQ; 000 NE; 010 LT (signed if `sign`, else unsigned); 110 LEZ; 101 LTZ; 111 GTZ.
  - LEZ/LTZ/GTZ always use a signed test of a.
  - Other codes give 0.

Sequential mult/div unit, FSM IDLE → RUN → FIN → IDLE:
- IDLE, `md_start`=1, `md_op`=MTHI/MTLO:
  - `hi` (or `lo`) ← a at that edge.
  - Stays IDLE; no busy, no done.
- IDLE, `md_start`=1, `md_op`=MULT/DIV:
  - Latch |a| and |b| (magnitudes if `md_sign`, else raw), the result-sign bits and the op.
  - Counter ← W−1; go to RUN.
- RUN: one iteration per cycle.
  - MULT: radix-2 shift-add into a 2W-bit accumulator.
  - DIV: restoring division, one quotient bit per cycle.
  - When counter = 0, go to FIN; otherwise decrement the counter.
- FIN: apply sign correction and write `hi`/`lo`; go to IDLE.
  - MULT: {hi,lo} ← 2W-bit product, negated if the operand signs differ and `md_sign`=1.
  - DIV: lo ← quotient, truncated toward zero; hi ← remainder, which carries the sign of the dividend.
  - Signed MIN/−1 gives lo=MIN, hi=0.
  - Divide by zero, either signedness: hi ← a as latched, lo ← all ones. No exception is raised.
- `md_busy` = (state ≠ IDLE).
- `md_start` while busy is ignored and has no side effects.
- `hi`/`lo` are never written during RUN.

## Timing
- Reset (sync, on any edge with `reset`=1, including mid-operation):
  - state ← IDLE; counter ← 0; `hi` ← 0; `lo` ← 0; `md_busy` = 0; `md_done` ← 0.
  - Any operation in flight is abandoned with no partial write.
- `z` and `ovf` are purely combinational, with 0-cycle latency.
- MULT/DIV start accepted at edge k:
  - `md_busy`=1 from edge k through edge k+W+1.
  - RUN occupies edges k+1..k+W; FIN is the edge k+W+1.
  - `hi`/`lo` are new and `md_done`=1 for exactly one cycle after edge k+W+1. `md_busy`=0 in that same cycle.
  - Latency is W+1 cycles.
- Back-to-back: `md_start` in the `md_done` cycle is accepted. Throughput is one op per W+2 cycles.
- MTHI/MTLO: 1-cycle write; the value is visible in the cycle after the edge.

## Test plan
- W=32, a=0x7FFFFFFF, b=1, fun=000000:
  - `sign`=1 → z=0x80000000, ovf=1.
  - `sign`=0 → same z, ovf=0.
- a=4, b=0xF0000000, fun=100011 → z=0xFF000000. fun=100001 → z=0x0F000000.
- MULT, `md_sign`=1, a=0xFFFFFFFE, b=3:
  - busy for 33 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, with a single done pulse.
- DIV, `md_sign`=1, a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Unsigned DIV a=7, b=2 → lo=3, hi=1.
- DIV a=0x1234, b=0 → hi=0x1234, lo=0xFFFFFFFF.
  - An MTLO start issued mid-operation is ignored: lo is unchanged until FIN.
- Start MULT, assert `reset` at RUN cycle 10:
  - Next cycle: busy=0, hi=lo=0, done=0.
  - A following MTHI a=0xA5 gives hi=0xA5.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with a sequential multiply/divide unit and HI/LO.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   a, b              operands (a[log2(W)-1:0] is the shift amount)
//   fun, sign         ALU function code and signed mode for ovf/compare
//   z, ovf            combinational ALU result and signed add/sub overflow
//   md_start, md_op   mult/div/move request; 00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//   md_sign           signed mult/div
//   md_busy, md_done  unit occupied; one-cycle completion pulse
//   hi, lo            HI/LO registers
module alu_md #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [5:0]   fun,
    input  logic         sign,
    output logic [W-1:0] z,
    output logic         ovf,
    input  logic         md_start,
    input  logic [1:0]   md_op,
    input  logic         md_sign,
    output logic         md_busy,
    output logic         md_done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned W2 = 2 * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [SW-1:0] shamt;
    logic [W-1:0]  bx;
    logic [W-1:0]  sum;
    logic [W-1:0]  bcmp;
    logic [W:0]    cdiff;
    logic          eq;
    logic          ltu;
    logic          lts;
    logic          flag;

    assign shamt = a[SW-1:0];

    // Adder, comparator subtract and result mux.
    always_comb begin
        bx    = fun[0] ? ~b : b;
        sum   = a + bx + W'(fun[0]);
        // Compare-against-zero codes use b' = 0
        bcmp  = (fun[5:3] == 3'b111) ? '0 : b;
        cdiff = {1'b0, a} - {1'b0, bcmp};
        eq    = (cdiff[W-1:0] == '0);
        ltu   = cdiff[W];
        lts   = (a[W-1] != bcmp[W-1]) ? a[W-1] : cdiff[W-1];

        flag = 1'b0;
        case (fun[3:1])
            3'b001:  flag = eq;
            3'b000:  flag = ~eq;
            3'b010:  flag = sign ? lts : ltu;
            3'b110:  flag = a[W-1] | eq;
            3'b101:  flag = a[W-1];
            3'b111:  flag = ~a[W-1] & ~eq;
            default: flag = 1'b0;
        endcase

        z   = '0;
        ovf = 1'b0;
        case (fun[5:4])
            2'b00: begin
                z   = sum;
                ovf = sign & (a[W-1] == bx[W-1]) & (sum[W-1] != a[W-1]);
            end
            2'b01: begin
                case (fun[3:0])
                    4'b1000: z = a & b;
                    4'b1110: z = a | b;
                    4'b0110: z = a ^ b;
                    4'b0001: z = ~(a | b);
                    4'b1010: z = a;
                    default: z = '0;
                endcase
            end
            2'b10: begin
                case (fun[1:0])
                    2'b00:   z = b << shamt;
                    2'b01:   z = b >> shamt;
                    2'b11:   z = $unsigned($signed(b) >>> shamt);
                    default: z = '0;
                endcase
            end
            default: z = {{(W-1){1'b0}}, flag};
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential multiply/divide unit
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W2-1:0] acc, acc_n;       // {partial/remainder, multiplier/quotient}
    logic [W-1:0]  mcand, mcand_n;   // multiplicand or divisor magnitude
    logic [W-1:0]  a_lat, a_lat_n;   // raw dividend for divide-by-zero
    logic          op_div, op_div_n;
    logic          neg_q, neg_q_n;   // product/quotient sign
    logic          neg_r, neg_r_n;   // remainder sign (dividend)
    logic          dz, dz_n;
    logic [W-1:0]  hi_n, lo_n;
    logic          busy_n, done_n;

    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    rs, trial, psum;
    logic [W2-1:0] prod;
    logic [W-1:0]  q, r;

    // Next-state and datapath update.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        mcand_n  = mcand;
        a_lat_n  = a_lat;
        op_div_n = op_div;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        dz_n     = dz;
        hi_n     = hi;
        lo_n     = lo;
        done_n   = 1'b0;

        a_mag = (md_sign && a[W-1]) ? (~a + W'(1)) : a;
        b_mag = (md_sign && b[W-1]) ? (~b + W'(1)) : b;
        rs    = {acc[W2-1:W], acc[W-1]};
        trial = rs - {1'b0, mcand};
        psum  = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
        prod  = neg_q ? (~acc + W2'(1)) : acc;
        q     = neg_q ? (~acc[W-1:0] + W'(1)) : acc[W-1:0];
        r     = neg_r ? (~acc[W2-1:W] + W'(1)) : acc[W2-1:W];

        case (state)
            S_IDLE: begin
                if (md_start) begin
                    case (md_op)
                        2'b10: hi_n = a;
                        2'b11: lo_n = a;
                        default: begin
                            op_div_n = md_op[0];
                            neg_q_n  = md_sign & (a[W-1] ^ b[W-1]);
                            neg_r_n  = md_sign & a[W-1];
                            dz_n     = (b == '0);
                            a_lat_n  = a;
                            mcand_n  = b_mag;
                            acc_n    = {{W{1'b0}}, a_mag};
                            cnt_n    = CW'(W - 1);
                            state_n  = S_RUN;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (op_div) begin
                    // Restoring step: keep the trial remainder when it does not borrow
                    if (!trial[W]) begin
                        acc_n = {trial[W-1:0], acc[W-2:0], 1'b1};
                    end else begin
                        acc_n = {rs[W-1:0], acc[W-2:0], 1'b0};
                    end
                end else begin
                    acc_n = {psum, acc[W-1:1]};
                end
                if (cnt == '0) begin
                    state_n = S_FIN;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_FIN: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
                if (op_div) begin
                    if (dz) begin
                        hi_n = a_lat;
                        lo_n = '1;
                    end else begin
                        hi_n = r;
                        lo_n = q;
                    end
                end else begin
                    {hi_n, lo_n} = prod;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            a_lat   <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            mcand   <= mcand_n;
            a_lat   <= a_lat_n;
            op_div  <= op_div_n;
            neg_q   <= neg_q_n;
            neg_r   <= neg_r_n;
            dz      <= dz_n;
            hi      <= hi_n;
            lo      <= lo_n;
            md_busy <= busy_n;
            md_done <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed self-checking bench for alu_md (W=32).
module tb_alu_md;

    logic        clk;
    logic        reset;
    logic [31:0] a, b, z, hi, lo;
    logic [5:0]  fun;
    logic        sign, ovf;
    logic        md_start, md_sign, md_busy, md_done;
    logic [1:0]  md_op;

    int tests = 0;
    int fails = 0;

    alu_md #(.W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .fun      (fun),
        .sign     (sign),
        .z        (z),
        .ovf      (ovf),
        .md_start (md_start),
        .md_op    (md_op),
        .md_sign  (md_sign),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fun;
        logic        sign;
        logic [31:0] z;
        logic        ov;
    } av_t;

    // Issue one md op (tasks start and end 1 time unit after a rising edge);
    // returns the number of busy cycles seen after acceptance.
    task automatic md_run(input logic [1:0] op, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          output int cyc);
        md_start = 1'b1; md_op = op; md_sign = s; a = x; b = y;
        @(posedge clk); #1;
        md_start = 1'b0; a = 32'h5A5A5A5A; b = 32'h3C3C3C3C;
        cyc = 0;
        while (md_busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; md_start = 1'b0; md_op = 2'b00; md_sign = 1'b0;
        a = '0; b = '0; fun = '0; sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
        tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", md_done); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        av_t tv[$];
        tv.push_back('{32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b1, 32'h80000000, 1'b1});
        tv.push_back('{32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b0, 32'h80000000, 1'b0});
        tv.push_back('{32'h80000000, 32'h00000001, 6'b000001, 1'b1, 32'h7FFFFFFF, 1'b1});
        tv.push_back('{32'h00000005, 32'h00000007, 6'b000001, 1'b1, 32'hFFFFFFFE, 1'b0});
        tv.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 6'b011000, 1'b0, 32'hF000F000, 1'b0});
        tv.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 6'b011110, 1'b0, 32'hFFF0FFF0, 1'b0});
        tv.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 6'b010110, 1'b0, 32'h0FF00FF0, 1'b0});
        tv.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 6'b010001, 1'b0, 32'h000F000F, 1'b0});
        tv.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 6'b011010, 1'b0, 32'hF0F0F0F0, 1'b0});
        tv.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 6'b010000, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'h7FFFFFFF, 32'h00000001, 6'b011110, 1'b1, 32'h7FFFFFFF, 1'b0});
        tv.push_back('{32'h00000004, 32'hF0000000, 6'b100011, 1'b0, 32'hFF000000, 1'b0});
        tv.push_back('{32'h00000004, 32'hF0000000, 6'b100001, 1'b0, 32'h0F000000, 1'b0});
        tv.push_back('{32'h00000024, 32'h0000000F, 6'b100000, 1'b0, 32'h000000F0, 1'b0});
        tv.push_back('{32'h00000004, 32'hF0000000, 6'b100010, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'h00000005, 32'h00000005, 6'b110010, 1'b0, 32'h00000001, 1'b0});
        tv.push_back('{32'h00000005, 32'h00000006, 6'b110000, 1'b0, 32'h00000001, 1'b0});
        tv.push_back('{32'h00000005, 32'h00000005, 6'b110000, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'hFFFFFFFF, 32'h00000001, 6'b110100, 1'b1, 32'h00000001, 1'b0});
        tv.push_back('{32'hFFFFFFFF, 32'h00000001, 6'b110100, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'h00000000, 32'h00000005, 6'b111100, 1'b0, 32'h00000001, 1'b0});
        tv.push_back('{32'h00000003, 32'h00000005, 6'b111100, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'h80000000, 32'h00000000, 6'b111010, 1'b0, 32'h00000001, 1'b0});
        tv.push_back('{32'h00000000, 32'h00000000, 6'b111010, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'h00000001, 32'h00000007, 6'b111110, 1'b0, 32'h00000001, 1'b0});
        tv.push_back('{32'h00000000, 32'h00000007, 6'b111110, 1'b0, 32'h00000000, 1'b0});
        tv.push_back('{32'h00000001, 32'h00000002, 6'b110110, 1'b1, 32'h00000000, 1'b0});
        foreach (tv[i]) begin
            a = tv[i].a; b = tv[i].b; fun = tv[i].fun; sign = tv[i].sign;
            #1;
            tests++;
            if (z !== tv[i].z) begin
                fails++; $display("FAIL alu_z[%0d] fun=%b: got %h expected %h", i, tv[i].fun, z, tv[i].z);
            end
            tests++;
            if (ovf !== tv[i].ov) begin
                fails++; $display("FAIL alu_ovf[%0d] fun=%b: got %b expected %b", i, tv[i].fun, ovf, tv[i].ov);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        logic [31:0] xa[5], xb[5], eh[5], el[5];
        logic        xs[5];
        int          cyc;
        xs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        xa = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00000007};
        xb = '{32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFD};
        eh = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        el = '{32'hFFFFFFFA, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFEB};
        for (int i = 0; i < 5; i++) begin
            md_run(2'b00, xs[i], xa[i], xb[i], cyc);
            tests++; if (cyc != 33) begin fails++; $display("FAIL mult_busy[%0d]: got %0d expected 33", i, cyc); end
            tests++; if (md_done !== 1'b1) begin fails++; $display("FAIL mult_done[%0d]: got %b expected 1", i, md_done); end
            tests++; if (hi !== eh[i]) begin fails++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi, eh[i]); end
            tests++; if (lo !== el[i]) begin fails++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo, el[i]); end
            @(posedge clk); #1;
            tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse[%0d]: got %b expected 0", i, md_done); end
        end
    endtask

    task automatic test_div();
        logic [31:0] xa[6], xb[6], eh[6], el[6];
        logic        xs[6];
        int          cyc;
        xs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        xa = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFF9};
        xb = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'h0000000A, 32'hFFFFFFFE, 32'hFFFFFFFE};
        el = '{32'hFFFFFFFD, 32'h00000003, 32'h80000000, 32'h19999999, 32'hFFFFFFFD, 32'h00000003};
        eh = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000005, 32'h00000001, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            md_run(2'b01, xs[i], xa[i], xb[i], cyc);
            tests++; if (cyc != 33) begin fails++; $display("FAIL div_busy[%0d]: got %0d expected 33", i, cyc); end
            tests++; if (md_done !== 1'b1) begin fails++; $display("FAIL div_done[%0d]: got %b expected 1", i, md_done); end
            tests++; if (lo !== el[i]) begin fails++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo, el[i]); end
            tests++; if (hi !== eh[i]) begin fails++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi, eh[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_divzero_mtlo();
        int cyc;
        // MTLO preload: visible in the next cycle, no busy/done
        md_start = 1'b1; md_op = 2'b11; a = 32'h11111111;
        @(posedge clk); #1;
        md_start = 1'b0;
        tests++; if (lo !== 32'h11111111) begin fails++; $display("FAIL mtlo_lo: got %h expected 11111111", lo); end
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL mtlo_busy: got %b expected 0", md_busy); end
        tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL mtlo_done: got %b expected 0", md_done); end
        // Unsigned divide by zero with an MTLO issued mid-run
        md_start = 1'b1; md_op = 2'b01; md_sign = 1'b0; a = 32'h00001234; b = 32'h0;
        @(posedge clk); #1;
        md_start = 1'b0;
        cyc = 0;
        while (md_busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                md_start = 1'b1; md_op = 2'b11; a = 32'hDEADBEEF;
            end else begin
                md_start = 1'b0;
            end
            if (cyc == 6) begin
                tests++;
                if (lo !== 32'h11111111) begin fails++; $display("FAIL mtlo_ignored: got %h expected 11111111", lo); end
            end
            @(posedge clk); #1;
        end
        md_start = 1'b0;
        tests++; if (cyc != 33) begin fails++; $display("FAIL dz_busy: got %0d expected 33", cyc); end
        tests++; if (hi !== 32'h00001234) begin fails++; $display("FAIL dz_hi: got %h expected 00001234", hi); end
        tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL dz_lo: got %h expected ffffffff", lo); end
        @(posedge clk); #1;
        // Signed divide by zero keeps the raw dividend
        md_run(2'b01, 1'b1, 32'hFFFFFFF9, 32'h0, cyc);
        tests++; if (hi !== 32'hFFFFFFF9) begin fails++; $display("FAIL dzs_hi: got %h expected fffffff9", hi); end
        tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL dzs_lo: got %h expected ffffffff", lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        md_run(2'b01, 1'b0, 32'd100, 32'd7, cyc);
        tests++; if (md_done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b expected 1", md_done); end
        tests++; if (lo !== 32'd14 || hi !== 32'd2) begin fails++; $display("FAIL b2b_first_result: got hi=%h lo=%h expected hi=2 lo=e", hi, lo); end
        // Start issued in the done cycle
        md_run(2'b00, 1'b0, 32'd3, 32'd5, cyc);
        tests++; if (cyc != 33) begin fails++; $display("FAIL b2b_busy: got %0d expected 33", cyc); end
        tests++; if (hi !== 32'h0 || lo !== 32'd15) begin fails++; $display("FAIL b2b_result: got hi=%h lo=%h expected hi=0 lo=f", hi, lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        md_start = 1'b1; md_op = 2'b00; md_sign = 1'b1; a = 32'hFFFFFFFE; b = 32'h3;
        @(posedge clk); #1;
        md_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL rmid_busy_before: got %b expected 1", md_busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b expected 0", md_busy); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL rmid_hilo: got hi=%h lo=%h expected 0", hi, lo); end
        tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL rmid_done: got %b expected 0", md_done); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_done === 1'b1 || md_busy === 1'b1) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL rmid_no_resume: got %0d active cycles expected 0", seen); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rmid_no_write: got lo=%h expected 0", lo); end
        md_start = 1'b1; md_op = 2'b10; a = 32'h000000A5;
        @(posedge clk); #1;
        md_start = 1'b0;
        tests++; if (hi !== 32'h000000A5) begin fails++; $display("FAIL mthi_after_reset: got %h expected 000000a5", hi); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_divzero_mtlo();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
